// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB wait-state completer
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] ADDR_ERRCNT  = 8'hFE;
  localparam logic [7:0] ADDR_XFERCNT = 8'hFF;
  localparam int         CNT_W        = 4;

endpackage

// File: rtl/apb_wait_ctrl.sv
// rtl/apb_wait_ctrl.sv - APB phase tracking FSM and wait-state counter
module apb_wait_ctrl
  import apb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   sel,
  input  logic   enable,
  output state_t state,
  output logic   ready,
  output logic   complete
);

  state_t             state_q;
  state_t             state_d;
  state_t             phase;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (phase == SETUP) begin
        cnt <= CNT_W'(WAIT_CYCLES);
      end else if (phase == ACCESS && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // state_q records the phase of the cycle just ended; the current phase
  // is resolved from it and the live bus so ACCESS is seen in its first cycle
  always_comb begin
    phase = IDLE;
    if (sel) begin
      if (!enable) begin
        phase = SETUP;
      end else if (state_q == SETUP || state_q == ACCESS) begin
        phase = ACCESS;
      end
    end
    state_d = (phase == ACCESS && cnt == '0) ? IDLE : phase;
  end

  always_comb begin
    state    = phase;
    ready    = (phase == ACCESS) && (cnt == '0);
    complete = ready;
  end

endmodule

// File: rtl/apb_wait_completer.sv
// rtl/apb_wait_completer.sv - APB completer with wait states, register file and status counters
// Optional error reporting and ERRCNT register enabled by APB_COMPLETER_ERR_EN.
module apb_wait_completer
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  logic [7:0]    mem [0:DEPTH-1];
  logic [7:0]    xfer_cnt;
  logic [AW-1:0] idx;
  state_t        state;
  logic          complete;
  logic          commit;
  logic          is_mem;
  logic          is_xfer;
  logic          legal;

  apb_wait_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_ctrl (
    .clk      (PCLK),
    .resetn   (PRESETn),
    .sel      (PSEL),
    .enable   (PENABLE),
    .state    (state),
    .ready    (PREADY),
    .complete (complete)
  );

  assign idx     = PADDR[AW-1:0];
  assign is_mem  = PADDR < DEPTH_B;
  assign is_xfer = PADDR == ADDR_XFERCNT;
  assign commit  = complete && (state == ACCESS);

`ifdef APB_COMPLETER_ERR_EN
  logic [7:0] err_cnt;
  logic       is_errcnt;

  assign is_errcnt = PADDR == ADDR_ERRCNT;
  assign legal     = PWRITE ? is_mem : (is_mem || is_xfer || is_errcnt);
  assign PSLVERR   = PREADY && !legal;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      err_cnt <= '0;
    end else if (commit && !legal && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign legal   = PWRITE ? is_mem : (is_mem || is_xfer);
  assign PSLVERR = 1'b0;
`endif

  // Counters and memory move only on the completing edge; aborts leave them alone
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      xfer_cnt <= '0;
    end else if (commit) begin
      if (PWRITE && is_mem) begin
        mem[idx] <= PWDATA;
      end
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PREADY && !PWRITE && legal) begin
      if (is_mem) begin
        PRDATA = mem[idx];
      end else if (is_xfer) begin
        PRDATA = xfer_cnt;
      end
`ifdef APB_COMPLETER_ERR_EN
      else begin
        PRDATA = err_cnt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_apb_wait_completer.sv
// tb/tb_apb_wait_completer.sv - directed scoreboard bench for apb_wait_completer
module tb_apb_wait_completer;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;
  localparam int AW    = $clog2(DEPTH);
`ifdef APB_COMPLETER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    logic       er;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [7:0] mdl [0:DEPTH-1];
  logic [7:0] m_x;
  logic [7:0] m_e;

  apb_wait_completer #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_pready"}, {7'd0, PREADY}, 8'h00);
    chk({tag, "_prdata"}, PRDATA, 8'h00);
    chk({tag, "_pslverr"}, {7'd0, PSLVERR}, 8'h00);
  endtask

  task automatic do_reset(input int n);
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 8'h00;
    PWDATA  = 8'h00;
    repeat (n) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    m_x = 8'h00;
    m_e = 8'h00;
  endtask

  // Full transfer; expectation pushed at drive time, popped when PREADY shows
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int   waits;
    bit   legal;
    legal = w ? (int'(a) < DEPTH)
              : (int'(a) < DEPTH || a == 8'hFF || (ERR_EN && a == 8'hFE));
    e.w  = w;
    e.a  = a;
    e.d  = d;
    e.er = ERR_EN && !legal;
    e.rd = 8'h00;
    if (!w && legal) begin
      if (int'(a) < DEPTH) e.rd = mdl[a[AW-1:0]];
      else if (a == 8'hFF) e.rd = m_x;
      else                 e.rd = m_e;
    end
    sb.push_back(e);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = w;
    PADDR   = a;
    PWDATA  = d;
    @(posedge PCLK);
    #1 PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (!PREADY && waits < 40) begin
      @(negedge PCLK);
      waits++;
    end
    chk("pready_seen", {7'd0, PREADY}, 8'h01);
    e = sb.pop_front();
    if (PREADY) begin
      chk("latency", 8'(waits), 8'(WAITC));
      chk($sformatf("prdata_%02h", e.a), PRDATA, e.rd);
      chk($sformatf("pslverr_%02h", e.a), {7'd0, PSLVERR}, {7'd0, e.er});
      if (e.w && int'(e.a) < DEPTH) mdl[e.a[AW-1:0]] = e.d;
      m_x = m_x + 8'd1;
      if (e.er && m_e != 8'hFF) m_e = m_e + 8'd1;
    end
    @(posedge PCLK);
    #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    do_reset(2);
    @(negedge PCLK);
    chk_outs_zero("reset");

    // first read after reset, then write/readback/status back-to-back
    xfer(1'b0, 8'h05, 8'h00);
    xfer(1'b1, 8'h10, 8'hA5);
    xfer(1'b0, 8'h10, 8'h00);
    xfer(1'b0, 8'hFF, 8'h00);
    @(posedge PCLK); #1;

    // illegal and read-only targets, plus the top legal byte
    xfer(1'b1, 8'h80, 8'h5A);
    xfer(1'b0, 8'h00, 8'h00);
    xfer(1'b0, 8'hFE, 8'h00);
    xfer(1'b0, 8'h40, 8'h00);
    xfer(1'b1, 8'hFF, 8'h33);
    xfer(1'b1, 8'h3F, 8'hC3);
    xfer(1'b0, 8'h3F, 8'h00);
    xfer(1'b0, 8'hFF, 8'h00);

    // abort on the second wait cycle
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h3C;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_wait1", {7'd0, PREADY}, 8'h00);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      chk("abort_idle", {7'd0, PREADY}, 8'h00);
    end
    @(posedge PCLK); #1;
    xfer(1'b0, 8'h00, 8'h00);
    xfer(1'b0, 8'hFF, 8'h00);

    // PENABLE without SETUP is ignored
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h02; PWDATA = 8'hEE;
    repeat (5) begin
      @(negedge PCLK);
      chk("no_setup", {7'd0, PREADY}, 8'h00);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    xfer(1'b0, 8'h02, 8'h00);

    // reset in the middle of an ACCESS phase
    xfer(1'b1, 8'h01, 8'h77);
    xfer(1'b0, 8'h01, 8'h00);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h03; PWDATA = 8'h99;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PRESETn = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    m_x = 8'h00;
    m_e = 8'h00;
    @(negedge PCLK);
    chk_outs_zero("mid_reset");
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    xfer(1'b0, 8'hFF, 8'h00);
    xfer(1'b0, 8'hFE, 8'h00);
    xfer(1'b0, 8'h01, 8'h00);
    xfer(1'b0, 8'h03, 8'h00);

    // XFERCNT wrap after 256 completions
    do_reset(1);
    for (int i = 0; i < 256; i++) xfer(1'b0, 8'h00, 8'h00);
    chk("model_wrap", m_x, 8'h00);
    xfer(1'b0, 8'hFF, 8'h00);

`ifdef APB_COMPLETER_ERR_EN
    // ERRCNT saturation
    for (int i = 0; i < 258; i++) xfer(1'b1, 8'hFE, 8'h11);
    xfer(1'b0, 8'hFE, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
